rails_feeder: RTL and testbench
===============================

Name: rails_feeder

Overview:
- Upstream stage of the rails checker. Accepts case records over a valid/ready byte stream and buffers up to two complete cases in ping-pong buffers.
- Replays each case to the checker with the exact timing it expects: one cycle with the car count, then N consecutive cycles of data1/data2.
- Captures the checker's valid/result1/result2 verdict and forwards it downstream, tagged with a case id.
- Holds the checker in reset (via rails_reset) whenever it has no case to play.

Parameters:
- MAXN, 10: largest legal car count per case; matches checker storage depth.
- TIMEOUT, 255: cycles to wait in P_WAIT for rails_valid before aborting the case.
- TW, 8: width of the timeout counter; must satisfy 2^TW > TIMEOUT.

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: asynchronous, active-high; clears all state.
- in_valid, input, 1: upstream word valid.
- in_ready, output, 1: feeder can accept a word.
- in_data, input, 8: header word is N in [3:0], [7:4] ignored. Body word is data1 in [3:0], data2 in [7:4].
- rails_reset, output, 1: registered; drives the checker's reset.
- number, output, 4: registered; to the checker.
- data1, output, 4: registered; to the checker.
- data2, output, 4: registered; to the checker.
- rails_valid, input, 1: checker valid.
- rails_r1, input, 1: checker result1.
- rails_r2, input, 1: checker result2.
- res_valid, output, 1: one-cycle verdict pulse.
- res_r1, output, 1: captured result1.
- res_r2, output, 1: captured result2.
- res_id, output, 8: case id; wraps 255 -> 0.
- res_timeout, output, 1: verdict is an abort; r1 and r2 are 0.
- err_hdr, output, 8: saturating count of illegal headers.

Behaviour:
- Reset values:
  - rails_reset=1; number, data1 and data2 = 0.
  - res_valid, res_r1, res_r2 and res_timeout = 0; res_id=0; err_hdr=0.
  - Both buffers empty; write pointer and read pointer = 0; in_ready=1 once reset deasserts.
- Handshake: a word transfers on a rising edge where in_valid && in_ready. in_ready = !(buffer[wptr] full).
- Write FSM:
  - W_HDR: N=0 or N>MAXN -> word dropped, err_hdr++, stay in W_HDR. Otherwise latch N, set k=0, go to W_BODY.
  - W_BODY: store the word at buf[wptr][k], k++. On k==N-1, mark buffer full, toggle wptr, go to W_HDR.
- Read FSM (states P_IDLE, P_NUM, P_DATA, P_WAIT):
  - P_IDLE: rails_reset=1. If buf[rptr] is full -> P_NUM; rails_reset is 0 from that cycle on.
  - P_NUM: exactly one cycle; number=N, data=0.
  - P_DATA: N cycles; data1/data2 = buf[rptr][j] for j=0..N-1; number=0.
  - P_WAIT: outputs 0; timeout counter counts up from 0.
    - On rails_valid=1: on the next cycle, res_valid=1 and res_r1/res_r2 carry the values sampled with valid, res_id = case count, res_timeout=0. Free buf[rptr], toggle rptr. If the other buffer is full -> P_NUM directly with no reset gap; else -> P_IDLE.
    - On counter==TIMEOUT without valid: res_valid=1 with res_timeout=1 and r1=r2=0. Free the buffer, toggle rptr, force P_IDLE (rails_reset=1 for at least one cycle).
- Simultaneous events:
  - A buffer freed and written in the same cycle: the free happens first, so a write to the same index is accepted only the next cycle (in_ready is registered from the full flags).
  - rails_valid is ignored outside P_WAIT.
- Reset mid-operation: an asynchronous reset aborts both FSMs. Partially written or queued cases are lost and no verdict is emitted.
- res_id increments by 1 per emitted verdict, including timeouts.

Test Plan:
- Header 5, body {1..5 / 1..5} with a checker model returning r1=1 and r2=1 -> rails_reset falls; number=5 for 1 cycle; 5 data cycles; res_valid pulse with r1=1, r2=1, id=0.
- Two cases sent back-to-back (N=3 then N=4) -> the second number cycle directly follows the verdict cycle with no rails_reset reassertion; ids 0 and 1.
- Three cases with in_valid held high -> in_ready=0 after two full buffers; the third is accepted only after the first verdict.
- Headers 0 and 11 followed by header 3 -> err_hdr=2, both illegal headers dropped, the case with N=3 plays normally.
- Checker never asserts valid -> after 255 cycles in P_WAIT: res_valid=1, res_timeout=1, rails_reset=1; the next case proceeds.
- Reset asserted during P_DATA -> rails_reset=1 and all outputs 0 immediately; no res_valid pulse follows.

Source files
------------

// File: rtl/rails_feeder_if.sv
// Upstream byte stream into the rails feeder: one word moves on a rising
// clock edge where in_valid and in_ready are both high.
interface rails_feeder_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;

  // Producer side: offers words, watches ready.
  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  // Consumer side: the feeder.
  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );
endinterface

// File: rtl/rails_feeder.sv
// rails_feeder: buffers up to two case records from a byte stream in
// ping-pong buffers, replays each one to the rails checker (count cycle,
// then N data cycles), and forwards the checker's verdict tagged with a
// case id. The checker is held in reset whenever no case is being played.
module rails_feeder #(
  parameter int MAXN    = 10,
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  rails_feeder_if.slave        stream,
  output logic                 rails_reset,
  output logic [3:0]           number,
  output logic [3:0]           data1,
  output logic [3:0]           data2,
  input  logic                 rails_valid,
  input  logic                 rails_r1,
  input  logic                 rails_r2,
  output logic                 res_valid,
  output logic                 res_r1,
  output logic                 res_r2,
  output logic [7:0]           res_id,
  output logic                 res_timeout,
  output logic [7:0]           err_hdr
);

  localparam logic [0:0] W_HDR  = 1'b0;
  localparam logic [0:0] W_BODY = 1'b1;

  localparam logic [1:0] P_IDLE = 2'd0;
  localparam logic [1:0] P_NUM  = 2'd1;
  localparam logic [1:0] P_DATA = 2'd2;
  localparam logic [1:0] P_WAIT = 2'd3;

  localparam logic [3:0]    MAXN_L    = 4'(MAXN);
  localparam logic [TW-1:0] TIMEOUT_L = TW'(TIMEOUT);

  // Case storage: one word per car, body word is {data2, data1}.
  logic [7:0] mem  [2][MAXN];
  logic [3:0] blen [2];
  logic [1:0] full;

  // Write side state.
  logic [0:0] wstate;
  logic       wptr;
  logic [3:0] wlen;
  logic [3:0] k;

  // Read side state.
  logic [1:0]    rstate;
  logic          rptr;
  logic [3:0]    j;
  logic [TW-1:0] tcnt;
  logic [7:0]    case_cnt;

  logic       accept;
  logic [3:0] hdr_n;
  logic       hdr_ok;
  logic       wr_done;
  logic       rd_free;

  assign stream.in_ready = !full[wptr];

  // Handshake decode and header legality.
  always_comb begin
    accept  = stream.in_valid && stream.in_ready;
    hdr_n   = stream.in_data[3:0];
    hdr_ok  = (hdr_n != 4'd0) && (hdr_n <= MAXN_L);
    wr_done = accept && (wstate == W_BODY) && (k == wlen - 4'd1);
    rd_free = (rstate == P_WAIT) && (rails_valid || (tcnt == TIMEOUT_L));
  end

  // Full flags: the writer only sets an empty buffer and the reader only
  // clears a full one, so both updates never target the same index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full <= '0;
    end else begin
      if (wr_done) full[wptr] <= 1'b1;
      if (rd_free) full[rptr] <= 1'b0;
    end
  end

  // Write FSM: header check, body count, buffer hand-off.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wstate  <= W_HDR;
      wptr    <= 1'b0;
      wlen    <= '0;
      k       <= '0;
      blen[0] <= '0;
      blen[1] <= '0;
      err_hdr <= '0;
    end else if (accept) begin
      case (wstate)
        W_HDR: begin
          if (hdr_ok) begin
            wlen       <= hdr_n;
            blen[wptr] <= hdr_n;
            k          <= '0;
            wstate     <= W_BODY;
          end else if (err_hdr != '1) begin
            err_hdr <= err_hdr + 8'd1;
          end
        end
        W_BODY: begin
          if (k == wlen - 4'd1) begin
            wptr   <= ~wptr;
            wstate <= W_HDR;
          end else begin
            k <= k + 4'd1;
          end
        end
        default: wstate <= W_HDR;
      endcase
    end
  end

  // Body word storage; contents are only read once the buffer is marked full.
  always_ff @(posedge clk) begin
    if (accept && (wstate == W_BODY)) mem[wptr][k] <= stream.in_data;
  end

  // Read FSM: outputs are registered together with the state they belong
  // to, so each transition loads the values of the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rstate      <= P_IDLE;
      rptr        <= 1'b0;
      j           <= '0;
      tcnt        <= '0;
      case_cnt    <= '0;
      rails_reset <= 1'b1;
      number      <= '0;
      data1       <= '0;
      data2       <= '0;
      res_valid   <= 1'b0;
      res_r1      <= 1'b0;
      res_r2      <= 1'b0;
      res_id      <= '0;
      res_timeout <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      case (rstate)
        P_IDLE: begin
          rails_reset <= 1'b1;
          number      <= '0;
          data1       <= '0;
          data2       <= '0;
          if (full[rptr]) begin
            rails_reset <= 1'b0;
            number      <= blen[rptr];
            rstate      <= P_NUM;
          end
        end
        P_NUM: begin
          number <= '0;
          data1  <= mem[rptr][4'd0][3:0];
          data2  <= mem[rptr][4'd0][7:4];
          j      <= '0;
          rstate <= P_DATA;
        end
        P_DATA: begin
          if (j == blen[rptr] - 4'd1) begin
            data1  <= '0;
            data2  <= '0;
            tcnt   <= '0;
            rstate <= P_WAIT;
          end else begin
            data1 <= mem[rptr][j + 4'd1][3:0];
            data2 <= mem[rptr][j + 4'd1][7:4];
            j     <= j + 4'd1;
          end
        end
        P_WAIT: begin
          if (rails_valid) begin
            res_valid   <= 1'b1;
            res_r1      <= rails_r1;
            res_r2      <= rails_r2;
            res_timeout <= 1'b0;
            res_id      <= case_cnt;
            case_cnt    <= case_cnt + 8'd1;
            rptr        <= ~rptr;
            // Next case already queued: go straight to its count cycle
            // without pulsing the checker reset.
            if (full[~rptr]) begin
              number <= blen[~rptr];
              rstate <= P_NUM;
            end else begin
              rails_reset <= 1'b1;
              rstate      <= P_IDLE;
            end
          end else if (tcnt == TIMEOUT_L) begin
            res_valid   <= 1'b1;
            res_r1      <= 1'b0;
            res_r2      <= 1'b0;
            res_timeout <= 1'b1;
            res_id      <= case_cnt;
            case_cnt    <= case_cnt + 8'd1;
            rptr        <= ~rptr;
            rails_reset <= 1'b1;
            rstate      <= P_IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: begin
          rails_reset <= 1'b1;
          rstate      <= P_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rails_feeder.sv
// Directed bench for rails_feeder with a small behavioural rails checker.
module tb_rails_feeder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rails_reset;
  logic [3:0] number, data1, data2;
  logic       rails_valid, rails_r1, rails_r2;
  logic       res_valid, res_r1, res_r2, res_timeout;
  logic [7:0] res_id, err_hdr;

  rails_feeder_if bus();

  rails_feeder #(.MAXN(10), .TIMEOUT(255), .TW(8)) dut (
    .clk(clk), .reset(reset), .stream(bus),
    .rails_reset(rails_reset), .number(number), .data1(data1), .data2(data2),
    .rails_valid(rails_valid), .rails_r1(rails_r1), .rails_r2(rails_r2),
    .res_valid(res_valid), .res_r1(res_r1), .res_r2(res_r2),
    .res_id(res_id), .res_timeout(res_timeout), .err_hdr(err_hdr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // Checker model controls.
  logic chk_en = 1'b1, chk_r1 = 1'b0, chk_r2 = 1'b0;
  int   chk_delay = 0;
  logic cm_valid = 1'b0, cm_r1 = 1'b0, cm_r2 = 1'b0, stray_valid = 1'b0;
  int   cm_st = 0, rem = 0, cnt = 0;

  assign rails_valid = cm_valid | stray_valid;
  assign rails_r1    = cm_r1;
  assign rails_r2    = cm_r2;

  typedef struct {
    logic       to;
    logic       r1;
    logic       r2;
    logic [7:0] id;
    logic       rr;
    int         cyc;
  } res_t;

  int         num_q[$];
  int         num_cyc_q[$];
  logic [7:0] dat_q[$];
  int         dat_cyc_q[$];
  res_t       res_q[$];
  res_t       mon_r;

  // Checker model and observation log: count cycle, N data cycles, then
  // an optional verdict pulse chk_delay cycles after the last data cycle.
  always @(negedge clk) begin
    if (res_valid) begin
      mon_r.to = res_timeout; mon_r.r1 = res_r1; mon_r.r2 = res_r2;
      mon_r.id = res_id; mon_r.rr = rails_reset; mon_r.cyc = cyc;
      res_q.push_back(mon_r);
    end
    if (rails_reset) begin
      cm_st = 0;
      cm_valid = 1'b0;
    end else begin
      if (cm_st == 3) begin
        cm_valid = 1'b0;
        cm_st = 0;
      end
      if (cm_st == 0) begin
        if (number != 4'd0) begin
          num_q.push_back(int'(number));
          num_cyc_q.push_back(cyc);
          rem = int'(number);
          cm_st = 1;
        end
      end else if (cm_st == 1) begin
        dat_q.push_back({data2, data1});
        dat_cyc_q.push_back(cyc);
        rem = rem - 1;
        if (rem == 0) begin
          cm_st = 2;
          cnt = chk_delay;
        end
      end else if (cm_st == 2) begin
        if (chk_en) begin
          if (cnt == 0) begin
            cm_valid = 1'b1;
            cm_r1 = chk_r1;
            cm_r2 = chk_r2;
            cm_st = 3;
          end else begin
            cnt = cnt - 1;
          end
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  int hs_cyc = 0;

  task automatic send(input logic [7:0] b);
    int t;
    t = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (!bus.in_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    hs_cyc = cyc;
    chk("send_accepted", 32'(t < 2000), 1);
    @(negedge clk);
  endtask

  task automatic send_all(input logic [7:0] v[$]);
    foreach (v[i]) send(v[i]);
  endtask

  task automatic wait_res(input int n, input int limit);
    int t;
    t = 0;
    while (res_q.size() < n && t < limit) begin
      @(negedge clk);
      t++;
    end
    chk("verdict_arrived", 32'(res_q.size() >= n), 1);
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    num_q.delete(); num_cyc_q.delete();
    dat_q.delete(); dat_cyc_q.delete();
    res_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v[$];
    int c_hs;

    bus.in_valid = 1'b0;
    bus.in_data  = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_rails_reset", 32'(rails_reset), 1);
    chk("rst_number", 32'(number), 0);
    chk("rst_data1", 32'(data1), 0);
    chk("rst_data2", 32'(data2), 0);
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_res_timeout", 32'(res_timeout), 0);
    chk("rst_res_id", 32'(res_id), 0);
    chk("rst_err_hdr", 32'(err_hdr), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 1);

    // Single case N=5, checker answers r1=1 r2=1 right away.
    chk_en = 1'b1; chk_r1 = 1'b1; chk_r2 = 1'b1; chk_delay = 0;
    v = '{8'h05, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    send_all(v);
    bus.in_valid = 1'b0;
    wait_res(1, 100);
    chk("t1_num_count", 32'(num_q.size()), 1);
    chk("t1_number", 32'(num_q[0]), 5);
    chk("t1_data_count", 32'(dat_q.size()), 5);
    for (int i = 0; i < 5; i++) chk("t1_data", 32'(dat_q[i]), 32'((i + 1) * 17));
    chk("t1_data_follows_num", 32'(dat_cyc_q[0] - num_cyc_q[0]), 1);
    chk("t1_r1", 32'(res_q[0].r1), 1);
    chk("t1_r2", 32'(res_q[0].r2), 1);
    chk("t1_id", 32'(res_q[0].id), 0);
    chk("t1_timeout", 32'(res_q[0].to), 0);
    chk("t1_verdict_latency", 32'(res_q[0].cyc - dat_cyc_q[4]), 2);
    chk("t1_rails_reset_back", 32'(res_q[0].rr), 1);
    repeat (5) @(negedge clk);
    chk("t1_single_pulse", 32'(res_q.size()), 1);

    // Back-to-back cases N=3 and N=4.
    do_reset();
    chk_r1 = 1'b1; chk_r2 = 1'b0; chk_delay = 2;
    v = '{8'h03, 8'hA1, 8'hB2, 8'hC3, 8'h04, 8'hD4, 8'hE5, 8'hF6, 8'h17};
    send_all(v);
    bus.in_valid = 1'b0;
    wait_res(2, 200);
    chk("t2_num0", 32'(num_q[0]), 3);
    chk("t2_num1", 32'(num_q[1]), 4);
    chk("t2_data2", 32'(dat_q[2]), 32'h00C3);
    chk("t2_data3", 32'(dat_q[3]), 32'h00D4);
    chk("t2_data6", 32'(dat_q[6]), 32'h0017);
    chk("t2_id0", 32'(res_q[0].id), 0);
    chk("t2_id1", 32'(res_q[1].id), 1);
    chk("t2_r1", 32'(res_q[0].r1), 1);
    chk("t2_r2", 32'(res_q[0].r2), 0);
    chk("t2_no_reset_gap", 32'(res_q[0].rr), 0);
    chk("t2_num_on_verdict_cycle", 32'(num_cyc_q[1] - res_q[0].cyc), 0);
    chk("t2_data_follows_num", 32'(dat_cyc_q[3] - num_cyc_q[1]), 1);

    // Three cases with in_valid held high; slow checker.
    do_reset();
    chk_r1 = 1'b0; chk_r2 = 1'b1; chk_delay = 20;
    v = '{8'h03, 8'h01, 8'h02, 8'h03, 8'h03, 8'h04, 8'h05, 8'h06};
    send_all(v);
    chk("t3_ready_low_when_full", 32'(bus.in_ready), 0);
    send(8'h03);
    c_hs = hs_cyc;
    v = '{8'h07, 8'h08, 8'h09};
    send_all(v);
    bus.in_valid = 1'b0;
    wait_res(3, 400);
    chk("t3_third_after_verdict", 32'(c_hs - res_q[0].cyc), 0);
    chk("t3_num_count", 32'(num_q.size()), 3);
    chk("t3_id2", 32'(res_q[2].id), 2);
    chk("t3_r1", 32'(res_q[2].r1), 0);
    chk("t3_r2", 32'(res_q[2].r2), 1);
    chk("t3_data8", 32'(dat_q[8]), 32'h0009);

    // Illegal headers, plus a stray checker valid while idle.
    do_reset();
    chk_r1 = 1'b1; chk_r2 = 1'b0; chk_delay = 0;
    stray_valid = 1'b1;
    @(negedge clk);
    stray_valid = 1'b0;
    send(8'h00);
    chk("t4_err_after_zero", 32'(err_hdr), 1);
    send(8'hFB);
    chk("t4_err_after_eleven", 32'(err_hdr), 2);
    v = '{8'h93, 8'h12, 8'h34, 8'h56};
    send_all(v);
    bus.in_valid = 1'b0;
    wait_res(1, 100);
    repeat (3) @(negedge clk);
    chk("t4_err_final", 32'(err_hdr), 2);
    chk("t4_num_count", 32'(num_q.size()), 1);
    chk("t4_number", 32'(num_q[0]), 3);
    chk("t4_data0", 32'(dat_q[0]), 32'h0012);
    chk("t4_data2", 32'(dat_q[2]), 32'h0056);
    chk("t4_res_count", 32'(res_q.size()), 1);
    chk("t4_id", 32'(res_q[0].id), 0);

    // Checker never answers: timeout verdict, then a normal case.
    do_reset();
    chk_en = 1'b0; chk_r1 = 1'b1; chk_r2 = 1'b1; chk_delay = 0;
    v = '{8'h03, 8'h21, 8'h22, 8'h23};
    send_all(v);
    bus.in_valid = 1'b0;
    wait_res(1, 400);
    chk("t5_timeout", 32'(res_q[0].to), 1);
    chk("t5_r1", 32'(res_q[0].r1), 0);
    chk("t5_r2", 32'(res_q[0].r2), 0);
    chk("t5_id", 32'(res_q[0].id), 0);
    chk("t5_rails_reset", 32'(res_q[0].rr), 1);
    chk("t5_timeout_latency", 32'(res_q[0].cyc - dat_cyc_q[2]), 257);
    chk_en = 1'b1; chk_r1 = 1'b0; chk_r2 = 1'b1;
    v = '{8'h03, 8'h31, 8'h32, 8'h33};
    send_all(v);
    bus.in_valid = 1'b0;
    wait_res(2, 100);
    chk("t5_next_timeout", 32'(res_q[1].to), 0);
    chk("t5_next_r2", 32'(res_q[1].r2), 1);
    chk("t5_next_id", 32'(res_q[1].id), 1);

    // Reset in the middle of the data phase.
    do_reset();
    chk_en = 1'b1; chk_delay = 0;
    v = '{8'h05, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
    send_all(v);
    bus.in_valid = 1'b0;
    begin
      int t;
      t = 0;
      while (dat_q.size() < 2 && t < 50) begin
        @(negedge clk);
        t++;
      end
      chk("t6_reached_data", 32'(dat_q.size() >= 2), 1);
    end
    reset = 1'b1;
    #1;
    chk("t6_rails_reset", 32'(rails_reset), 1);
    chk("t6_number", 32'(number), 0);
    chk("t6_data1", 32'(data1), 0);
    chk("t6_data2", 32'(data2), 0);
    chk("t6_res_valid", 32'(res_valid), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    res_q.delete();
    num_q.delete();
    repeat (50) @(negedge clk);
    chk("t6_no_verdict", 32'(res_q.size()), 0);
    chk("t6_no_replay", 32'(num_q.size()), 0);
    chk("t6_in_ready", 32'(bus.in_ready), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
